// File: rtl/mac_sweep_control_pkg.sv
// Shared types and constants for the MAC coefficient sweep controller.
// State encoding, mode constants and the address-width helper live here.
package mac_sweep_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic MODE_FULL   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // Sample address is {x,y}, so it needs two block-edge indices.
    function automatic int addr_w_of(input int log2n);
        return 2 * log2n;
    endfunction

endpackage

// File: rtl/mac_sweep_control_lat_pipe.sv
// RD_LAT-deep, 2-bit shift register that lines the read strobe and the
// first-sample flag up with data arriving at the MAC inputs.
module mac_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [RD_LAT-1:0][1:0] stage_q;
    logic [RD_LAT-1:0][1:0] stage_d;

    always_comb begin
        stage_d    = '0;
        stage_d[0] = din;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[RD_LAT-1];

endmodule

// File: rtl/mac_sweep_control.sv
// Sweep controller: streams N*N sample reads per coefficient (u,v), drives the
// MAC enable/clear through the read-latency pipe and hands off each result.
module mac_sweep_control
    import mac_sweep_control_pkg::*;
#(
    parameter int LOG2N  = 3,
    parameter int RD_LAT = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Mode,
    input  logic [LOG2N-1:0]     U_In,
    input  logic [LOG2N-1:0]     V_In,
    input  logic                 Coef_Ready,
    output logic [LOG2N-1:0]     u,
    output logic [LOG2N-1:0]     v,
    output logic [LOG2N-1:0]     x,
    output logic [LOG2N-1:0]     y,
    output logic [2*LOG2N-1:0]   Address,
    output logic                 Read_Enable,
    output logic                 Active_MAC,
    output logic                 Clear_MAC,
    output logic                 Coef_Valid,
    output logic                 Busy,
    output logic                 Ready,
    output state_t               State_Dbg
);

    localparam int               ADDR_W     = addr_w_of(LOG2N);
    localparam logic [LOG2N-1:0] LAST       = '1;
    localparam logic [1:0]       DRAIN_LOAD = 2'(RD_LAT - 1);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [LOG2N-1:0] u_q, u_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic [1:0]       drain_q, drain_d;
    logic             re_q, re_d, cv_q, cv_d, busy_q, busy_d, rdy_q, rdy_d;
    logic             first_issue;
    logic [1:0]       pipe_out;

    // Handshake: Coef_Valid stays high with u/v frozen until a cycle where
    // Coef_Ready is also high; that cycle is the transfer of the coefficient.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        u_d     = u_q;
        v_d     = v_q;
        x_d     = x_q;
        y_d     = y_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    mode_d  = Mode;
                    u_d     = (Mode == MODE_SINGLE) ? U_In : '0;
                    v_d     = (Mode == MODE_SINGLE) ? V_In : '0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                y_d = y_q + 1'b1;
                if (y_q == LAST) begin
                    x_d = x_q + 1'b1;
                    if (x_q == LAST) begin
                        drain_d = DRAIN_LOAD;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = ST_EMIT;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_EMIT: begin
                if (Coef_Ready) begin
                    if (mode_q == MODE_SINGLE || (u_q == LAST && v_q == LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        v_d = v_q + 1'b1;
                        if (v_q == LAST) begin
                            u_d = u_q + 1'b1;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                u_d     = '0;
                v_d     = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered, so they are decoded from the next state.
        re_d   = (state_d == ST_ISSUE);
        cv_d   = (state_d == ST_EMIT);
        busy_d = (state_d != ST_IDLE);
        rdy_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FULL;
            u_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drain_q <= '0;
            re_q    <= 1'b0;
            cv_q    <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drain_q <= drain_d;
            re_q    <= re_d;
            cv_q    <= cv_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    // The (0,0) read of every coefficient is the one whose product must load the MAC.
    assign first_issue = re_q && (x_q == '0) && (y_q == '0);

    mac_lat_pipe #(
        .RD_LAT(RD_LAT)
    ) u_lat_pipe (
        .clk  (Clock),
        .rst  (Reset),
        .din  ({re_q, first_issue}),
        .dout (pipe_out)
    );

    assign u           = u_q;
    assign v           = v_q;
    assign x           = x_q;
    assign y           = y_q;
    assign Address     = ADDR_W'({x_q, y_q});
    assign Read_Enable = re_q;
    assign Active_MAC  = pipe_out[1];
    assign Clear_MAC   = pipe_out[0];
    assign Coef_Valid  = cv_q;
    assign Busy        = busy_q;
    assign Ready       = rdy_q;
    assign State_Dbg   = state_q;

endmodule

// File: tb/tb_mac_sweep_control.sv
// Directed bench for mac_sweep_control: three parameterisations share one
// clock; a closed-form timing model supplies the expected per-cycle outputs.
module tb_mac_sweep_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [2:0] u_in, v_in;
    logic       coef_ready;
    int         sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance A: LOG2N=3, RD_LAT=1
    logic [2:0] a_u, a_v, a_x, a_y, a_st;
    logic [5:0] a_addr;
    logic       a_re, a_act, a_clr, a_cv, a_busy, a_rdy;
    // Instance B: LOG2N=2, RD_LAT=3
    logic [1:0] b_u, b_v, b_x, b_y;
    logic [2:0] b_st;
    logic [3:0] b_addr;
    logic       b_re, b_act, b_clr, b_cv, b_busy, b_rdy;
    // Instance C: LOG2N=2, RD_LAT=4
    logic [1:0] c_u, c_v, c_x, c_y;
    logic [2:0] c_st;
    logic [3:0] c_addr;
    logic       c_re, c_act, c_clr, c_cv, c_busy, c_rdy;

    mac_sweep_control #(.LOG2N(3), .RD_LAT(1)) dut_a (
        .Clock(clk), .Reset(rst), .Start(start && sel == 0), .Mode(mode),
        .U_In(u_in), .V_In(v_in), .Coef_Ready(coef_ready),
        .u(a_u), .v(a_v), .x(a_x), .y(a_y), .Address(a_addr),
        .Read_Enable(a_re), .Active_MAC(a_act), .Clear_MAC(a_clr),
        .Coef_Valid(a_cv), .Busy(a_busy), .Ready(a_rdy), .State_Dbg(a_st)
    );

    mac_sweep_control #(.LOG2N(2), .RD_LAT(3)) dut_b (
        .Clock(clk), .Reset(rst), .Start(start && sel == 1), .Mode(mode),
        .U_In(u_in[1:0]), .V_In(v_in[1:0]), .Coef_Ready(coef_ready),
        .u(b_u), .v(b_v), .x(b_x), .y(b_y), .Address(b_addr),
        .Read_Enable(b_re), .Active_MAC(b_act), .Clear_MAC(b_clr),
        .Coef_Valid(b_cv), .Busy(b_busy), .Ready(b_rdy), .State_Dbg(b_st)
    );

    mac_sweep_control #(.LOG2N(2), .RD_LAT(4)) dut_c (
        .Clock(clk), .Reset(rst), .Start(start && sel == 2), .Mode(mode),
        .U_In(u_in[1:0]), .V_In(v_in[1:0]), .Coef_Ready(coef_ready),
        .u(c_u), .v(c_v), .x(c_x), .y(c_y), .Address(c_addr),
        .Read_Enable(c_re), .Active_MAC(c_act), .Clear_MAC(c_clr),
        .Coef_Valid(c_cv), .Busy(c_busy), .Ready(c_rdy), .State_Dbg(c_st)
    );

    // Packed view: {re,act,clr,cv,rdy,busy,u[3],v[3],x[3],y[3],addr[6]}
    logic [23:0] obs_a, obs_b, obs_c, obs;
    logic [2:0]  obs_st;
    assign obs_a = {a_re, a_act, a_clr, a_cv, a_rdy, a_busy, a_u, a_v, a_x, a_y, a_addr};
    assign obs_b = {b_re, b_act, b_clr, b_cv, b_rdy, b_busy, 1'b0, b_u, 1'b0, b_v,
                    1'b0, b_x, 1'b0, b_y, 2'b00, b_addr};
    assign obs_c = {c_re, c_act, c_clr, c_cv, c_rdy, c_busy, 1'b0, c_u, 1'b0, c_v,
                    1'b0, c_x, 1'b0, c_y, 2'b00, c_addr};
    assign obs    = (sel == 0) ? obs_a : (sel == 1) ? obs_b : obs_c;
    assign obs_st = (sel == 0) ? a_st  : (sel == 1) ? b_st  : c_st;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs in cycle c after the Start edge with Coef_Ready held high.
    function automatic logic [23:0] model(input int c, input int log2n, input int rd_lat,
                                          input logic md, input int u0, input int v0,
                                          input int n_coef);
        int n, nn, per, total, k, r, uu, vv, xx, yy;
        logic re, act, clr, cv, rdy, busy;
        n     = 1 << log2n;
        nn    = n * n;
        per   = nn + rd_lat + 1;
        total = n_coef * per + 1;
        re = 0; act = 0; clr = 0; cv = 0; rdy = 0; busy = 0;
        uu = 0; vv = 0; xx = 0; yy = 0;
        if (c == total) begin
            rdy  = 1;
            busy = 1;
            uu   = md ? u0 : n - 1;
            vv   = md ? v0 : n - 1;
        end else if (c < total) begin
            k    = (c - 1) / per;
            r    = (c - 1) % per;
            busy = 1;
            uu   = md ? u0 : k / n;
            vv   = md ? v0 : k % n;
            re   = (r < nn);
            xx   = re ? r / n : 0;
            yy   = re ? r % n : 0;
            act  = (r >= rd_lat) && (r < nn + rd_lat);
            clr  = (r == rd_lat);
            cv   = (r == nn + rd_lat);
        end
        return {re, act, clr, cv, rdy, busy, 3'(uu), 3'(vv), 3'(xx), 3'(yy), 6'(xx * n + yy)};
    endfunction

    task automatic run_op(input int which, input int log2n, input int rd_lat, input logic md,
                          input int u0, input int v0, input int n_coef,
                          input int pulse1, input int pulse2);
        int total, ready_at;
        total      = n_coef * ((1 << (2 * log2n)) + rd_lat + 1) + 1;
        ready_at   = 0;
        sel        = which;
        mode       = md;
        u_in       = u0[2:0];
        v_in       = v0[2:0];
        coef_ready = 1'b1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        for (int c = 1; c <= total + 3; c++) begin
            check($sformatf("op%0d_cyc%0d", which, c), 32'(obs),
                  32'(model(c, log2n, rd_lat, md, u0, v0, n_coef)));
            if (obs[19] && ready_at == 0) ready_at = c;
            start = (c == pulse1) || (c == pulse2);
            step();
        end
        start = 1'b0;
        check($sformatf("op%0d_ready_lat", which), ready_at, total);
    endtask

    initial begin
        int cnt, bad;
        rst        = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        u_in       = '0;
        v_in       = '0;
        coef_ready = 1'b1;
        sel        = 0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check($sformatf("reset_outs%0d", i), 32'(obs), 32'd0);
            check($sformatf("reset_state%0d", i), 32'(obs_st), 32'd0);
        end
        rst = 1'b0;
        step();

        // Single coefficient (2,5), N=8, RD_LAT=1: Ready at cycle 67.
        run_op(0, 3, 1, 1'b1, 2, 5, 1, 0, 0);
        // Full sweep, N=4, RD_LAT=3: 16 coefficients, Ready at cycle 321.
        run_op(1, 2, 3, 1'b0, 0, 0, 16, 0, 0);
        // Full sweep, N=4, RD_LAT=4: Active_MAC trails Read_Enable by 4.
        run_op(2, 2, 4, 1'b0, 0, 0, 16, 0, 0);
        // Start pulsed during ISSUE (cycle 10) and EMIT (cycle 66) is ignored.
        run_op(0, 3, 1, 1'b1, 7, 7, 1, 10, 66);

        // Start held high: restart one cycle after DONE.
        sel = 1; mode = 1'b1; u_in = 3'd1; v_in = 3'd2; coef_ready = 1'b1;
        start = 1'b1;
        step();
        cnt = 1;
        while (!obs[19] && cnt < 100) begin
            step();
            cnt++;
        end
        check("held_ready_cyc", cnt, 21);
        step();
        check("held_idle_gap", {obs[23], obs[18]}, 2'b00);
        step();
        check("held_restart", {obs[23], obs[18], obs[17:12]}, {1'b1, 1'b1, 3'd1, 3'd2});
        start = 1'b0;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        step();

        // Backpressure in the first EMIT of a full sweep, then abort by reset.
        sel = 0; mode = 1'b0; u_in = '0; v_in = '0; coef_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        while (!obs[20] && cnt < 200) begin
            step();
            cnt++;
        end
        check("bp_emit_wait", cnt, 65);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i), {obs[23], obs[20], obs[17:12]}, {1'b0, 1'b1, 6'd0});
            step();
        end
        coef_ready = 1'b1;
        check("bp_hold_last", {obs[23], obs[20], obs[17:12]}, {1'b0, 1'b1, 6'd0});
        step();
        check("bp_resume", {obs[23], obs[20], obs[17:6]}, {1'b1, 1'b0, 3'd0, 3'd1, 6'd0});
        repeat (29) step();
        check("abort_at_xy", obs[11:6], {3'd3, 3'd5});
        #2 rst = 1'b1;
        #1;
        check("abort_outs", 32'(obs), 32'd0);
        check("abort_state", 32'(obs_st), 32'd0);
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (obs[19] || obs[18]) bad++;
        end
        check("abort_no_ready", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_sweep_control.md
Name: mac_sweep_control

Overview:
- Parametrised successor of the 8x8 transform sweep FSM.
- For each output coefficient (u,v) it streams all N*N sample addresses (x,y) at one read per cycle.
- It drives the MAC enable and clear through a read-latency-matched pipeline, then presents each finished coefficient on a valid/ready handshake.
- Supports a full 2-D sweep mode and a single-coefficient mode. Sits between Start/Ready control, sample/coefficient ROMs and the MAC accumulator.

Parameters:
- LOG2N, 3, log2 of block edge N (N = 2**LOG2N); legal 1..5.
- RD_LAT, 1, cycles from Read_Enable to data present at MAC inputs; legal 1..4.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin an operation; sampled only in IDLE.
- Mode  in  1  0 = full sweep of all (u,v); 1 = single coefficient at U_In/V_In; latched on accepted Start.
- U_In  in  LOG2N  coefficient row for Mode=1; latched on Start.
- V_In  in  LOG2N  coefficient column for Mode=1; latched on Start.
- Coef_Ready  in  1  downstream accepts the current coefficient.
- u  out  LOG2N  current coefficient row.
- v  out  LOG2N  current coefficient column.
- x  out  LOG2N  sample row being issued.
- y  out  LOG2N  sample column being issued.
- Address  out  2*LOG2N  sample address {x,y}.
- Read_Enable  out  1  read strobe, high during ISSUE.
- Active_MAC  out  1  Read_Enable delayed RD_LAT cycles.
- Clear_MAC  out  1  high with the first Active_MAC of each coefficient (MAC loads the product instead of adding it).
- Coef_Valid  out  1  finished coefficient available (state EMIT).
- Busy  out  1  state != IDLE.
- Ready  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset: state IDLE; u, v, x, y, Address = 0; Read_Enable, Active_MAC, Clear_MAC, Coef_Valid, Busy, Ready = 0; latency pipeline flushed; Mode latch = 0.
- Reset mid-operation aborts immediately. No Ready pulse is issued for an aborted operation.
- States: IDLE, ISSUE, DRAIN, EMIT, DONE.
- IDLE:
  - Start=1 latches Mode, U_In and V_In, and goes to ISSUE.
  - Start edge: u,v = 0,0 for Mode=0, or U_In,V_In for Mode=1. x,y = 0.
  - Start=0 stays in IDLE.
- ISSUE:
  - Read_Enable=1 every cycle. Address = {x,y}.
  - y increments each cycle. At y = N-1, y wraps to 0 and x increments.
  - The first issue of each coefficient sets a "first" flag that travels with the pipeline.
  - When x = y = N-1 is issued: go to DRAIN and load the drain counter with RD_LAT-1.
  - x,y return to 0.
- Pipeline:
  - RD_LAT-deep shift registers carry Read_Enable and the first flag.
  - Active_MAC and Clear_MAC are the delayed copies.
  - They are combinational from the registers, with no extra delay.
- DRAIN:
  - Read_Enable=0.
  - Stay until the counter reaches 0, i.e. RD_LAT cycles in total, then go to EMIT.
  - The last Active_MAC occurs in the final DRAIN cycle.
- EMIT:
  - Coef_Valid=1. u and v are held stable.
  - Coef_Ready=0 holds EMIT indefinitely. No reads are issued.
  - On Coef_Ready=1, if Mode=1 or (u,v) = (N-1,N-1), go to DONE.
  - Otherwise v increments; at v = N-1, v wraps to 0 and u increments. Then go back to ISSUE.
- DONE:
  - Ready=1 for one cycle, then go to IDLE.
  - u and v are cleared to 0 on the transition to IDLE.
- Start while Busy is ignored.
- Start=1 held continuously restarts from IDLE one cycle after DONE.
- Timing (Coef_Ready tied high): N*N + RD_LAT + 1 cycles per coefficient.
- Ready is asserted (coefficients * (N*N + RD_LAT + 1)) + 1 cycles after the Start edge.
- Counter arithmetic is LOG2N-bit modulo. Wrap occurs only at the points defined above. No other overflow paths exist.

Decomposition:
- Shared package:
  - state encoding (IDLE=0, ISSUE=1, DRAIN=2, EMIT=3, DONE=4, 3 bits);
  - mode constants MODE_FULL=0, MODE_SINGLE=1;
  - derived width constant ADDR_W = 2*LOG2N.
- One sub-module, mac_lat_pipe: an RD_LAT-deep, 2-bit-wide shift register with asynchronous reset. It produces Active_MAC and Clear_MAC.

Test Plan:
- Reset during ISSUE at x=3,y=5 (LOG2N=3) -> all outputs 0 and IDLE in the same cycle; no Ready pulse afterwards.
- Mode=1, U_In=2, V_In=5, RD_LAT=1, Coef_Ready=1 -> expected response:
  - 64 Read_Enable cycles with Address 0..63 in order;
  - Clear_MAC only on the first Active_MAC;
  - Coef_Valid with u=2, v=5;
  - Ready 67 cycles after the Start edge.
- Mode=0, LOG2N=2, RD_LAT=3, Coef_Ready=1 -> 16 coefficients with (u,v) in order (0,0)..(3,3); Ready 16*20+1 = 321 cycles after Start.
- Backpressure: Coef_Ready held low for 10 cycles in the first EMIT -> Coef_Valid is held and u/v are stable; no Read_Enable; the sweep resumes with v=1.
- Start pulsed during ISSUE and during EMIT -> ignored; the cycle count is unchanged.
- RD_LAT=4 -> Active_MAC equals Read_Enable delayed exactly 4 cycles; the last Active_MAC falls in the final DRAIN cycle, before Coef_Valid.
